// File: rtl/vga_params.sv
// Shared constants and elaboration-time helpers for the VGA read-address path.
package vga_params;

   localparam int DEFAULT_H_ACTIVE = 640;
   localparam int DEFAULT_V_ACTIVE = 480;

   // Bits needed to hold the values 0..value-1, never less than one bit.
   function automatic int clog2(input int value);
      int width;
      width = 1;
      while ((1 << width) < value) begin
         width = width + 1;
      end
      return width;
   endfunction

   // Number of source pixels in one stored frame after downscaling by 2^s.
   function automatic int stride_of(input int h_active, input int v_active, input int s);
      return (h_active >> s) * (v_active >> s);
   endfunction

endpackage

// File: rtl/vga_scaled_axis_counter.sv
// Modulo-N screen position counter for one axis. The low S bits of the
// position act as the replication prescaler, so the source index moves on
// once every 2^S steps.
module vga_scaled_axis_counter
   import vga_params::*;
#(
   parameter int N = DEFAULT_H_ACTIVE,
   parameter int S = 0,
   parameter int W = clog2(N)
)
(
   input  logic         clock,
   input  logic         reset,
   input  logic         step,
   input  logic         clear,
   output logic [W-1:0] pos,
   output logic         last,
   output logic         wrap,
   output logic         src_inc
);

   localparam logic [W-1:0] LAST_POS = W'(N - 1);
   localparam logic [W-1:0] REP_MASK = W'((1 << S) - 1);

   logic rep_last;

   // Decodes from the registered position: last pixel of the axis, and last
   // replica of the current source pixel. A step on a final replica that is
   // not the axis end moves to the next source index.
   assign last     = (pos == LAST_POS);
   assign rep_last = ((pos & REP_MASK) == REP_MASK);
   assign wrap     = step & last;
   assign src_inc  = step & rep_last & ~last;

   // Position register: clear wins over step, step wraps modulo N.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pos <= '0;
      end else if (clear) begin
         pos <= '0;
      end else if (step) begin
         pos <= last ? '0 : pos + W'(1);
      end
   end

endmodule

// File: rtl/vga_frame_addr_gen.sv
// Frame-buffer read address generator with 2^S upscaling and frame-boundary
// buffer selection. The address is built incrementally from a buffer base, a
// source line base and a source column index, so no multipliers are needed.
module vga_frame_addr_gen
   import vga_params::*;
#(
   parameter int H_ACTIVE   = DEFAULT_H_ACTIVE,
   parameter int V_ACTIVE   = DEFAULT_V_ACTIVE,
   parameter int SCALE_LOG2 = 0,
   parameter int NUM_BUFS   = 2,
   parameter int ADDR_W     = 20,
   parameter int BSEL_W     = 1
)
(
   input  logic                          clock,
   input  logic                          reset,
   input  logic                          enable,
   input  logic                          restart,
   input  logic [BSEL_W-1:0]             buf_sel,
   output logic [ADDR_W-1:0]             read_address,
   output logic [clog2(H_ACTIVE)-1:0]    x_pos,
   output logic [clog2(V_ACTIVE)-1:0]    y_pos,
   output logic [BSEL_W-1:0]             active_buf,
   output logic                          line_end,
   output logic                          frame_end,
   output logic                          frame_done
);

   localparam int XW     = clog2(H_ACTIVE);
   localparam int YW     = clog2(V_ACTIVE);
   localparam int SRC_W  = H_ACTIVE >> SCALE_LOG2;
   localparam int STRIDE = stride_of(H_ACTIVE, V_ACTIVE, SCALE_LOG2);

   localparam logic [ADDR_W-1:0] SRC_W_A = ADDR_W'(SRC_W);

   logic              advance;
   logic              x_last;
   logic              x_wrap;
   logic              x_src_inc;
   logic              y_last;
   logic              y_wrap;
   logic              y_src_inc;
   logic              frame_wrap;
   logic              sel_valid;
   logic [ADDR_W-1:0] sel_base;

   logic [XW-1:0]     col;
   logic [ADDR_W-1:0] line_base;
   logic [ADDR_W-1:0] buf_base;
   logic [XW-1:0]     col_n;
   logic [ADDR_W-1:0] line_n;
   logic [ADDR_W-1:0] buf_n;
   logic [BSEL_W-1:0] abuf_n;

   // restart outranks enable, so a restart cycle never advances the position.
   assign advance = enable & ~restart;

   vga_scaled_axis_counter #(
      .N (H_ACTIVE),
      .S (SCALE_LOG2),
      .W (XW)
   ) x_axis (
      .clock   (clock),
      .reset   (reset),
      .step    (advance),
      .clear   (restart),
      .pos     (x_pos),
      .last    (x_last),
      .wrap    (x_wrap),
      .src_inc (x_src_inc)
   );

   // The line counter only moves when the column counter wraps.
   vga_scaled_axis_counter #(
      .N (V_ACTIVE),
      .S (SCALE_LOG2),
      .W (YW)
   ) y_axis (
      .clock   (clock),
      .reset   (reset),
      .step    (x_wrap),
      .clear   (restart),
      .pos     (y_pos),
      .last    (y_last),
      .wrap    (y_wrap),
      .src_inc (y_src_inc)
   );

   assign frame_wrap = y_wrap;
   assign line_end   = x_last;
   assign frame_end  = x_last & y_last;
   assign sel_valid  = (32'(buf_sel) < NUM_BUFS);

   // Base address of the requested buffer, chosen from per-buffer constants.
   always_comb begin
      sel_base = '0;
      for (int i = 0; i < NUM_BUFS; i++) begin
         if (32'(buf_sel) == i) begin
            sel_base = ADDR_W'(i * STRIDE);
         end
      end
   end

   // Next column/line/buffer values. A line wrap either steps the line base to
   // the next source line or leaves it at the start of the current one so the
   // same source line is replayed for the replicated screen lines.
   always_comb begin
      col_n  = col;
      line_n = line_base;
      buf_n  = buf_base;
      abuf_n = active_buf;
      if (restart || frame_wrap) begin
         col_n  = '0;
         line_n = '0;
         if (sel_valid) begin
            buf_n  = sel_base;
            abuf_n = buf_sel;
         end
      end else if (x_wrap) begin
         col_n = '0;
         if (y_src_inc) begin
            line_n = line_base + SRC_W_A;
         end
      end else if (x_src_inc) begin
         col_n = col + XW'(1);
      end
   end

   // Address state, registered address sum, buffer latch and end-of-frame pulse.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         col          <= '0;
         line_base    <= '0;
         buf_base     <= '0;
         active_buf   <= '0;
         read_address <= '0;
         frame_done   <= 1'b0;
      end else begin
         col          <= col_n;
         line_base    <= line_n;
         buf_base     <= buf_n;
         active_buf   <= abuf_n;
         read_address <= buf_n + line_n + ADDR_W'(col_n);
         frame_done   <= frame_wrap;
      end
   end

endmodule

// File: tb/tb_vga_frame_addr_gen.sv
// Bench for vga_frame_addr_gen: 8x4 screen, 2x upscaling, two buffers.
// A pixel-index reference model predicts every output after each clock.
module tb_vga_frame_addr_gen;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int S  = 1;
   localparam int NB = 2;
   localparam int AW = 5;
   localparam int BW = 2;

   logic          clock   = 1'b0;
   logic          reset   = 1'b0;
   logic          enable  = 1'b0;
   logic          restart = 1'b0;
   logic [BW-1:0] buf_sel = '0;

   logic [AW-1:0] read_address;
   logic [2:0]    x_pos;
   logic [1:0]    y_pos;
   logic [BW-1:0] active_buf;
   logic          line_end;
   logic          frame_end;
   logic          frame_done;

   int total = 0;
   int bad   = 0;

   int mx    = 0;
   int my    = 0;
   int mbuf  = 0;
   int mdone = 0;

   vga_frame_addr_gen #(
      .H_ACTIVE   (H),
      .V_ACTIVE   (V),
      .SCALE_LOG2 (S),
      .NUM_BUFS   (NB),
      .ADDR_W     (AW),
      .BSEL_W     (BW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .enable       (enable),
      .restart      (restart),
      .buf_sel      (buf_sel),
      .read_address (read_address),
      .x_pos        (x_pos),
      .y_pos        (y_pos),
      .active_buf   (active_buf),
      .line_end     (line_end),
      .frame_end    (frame_end),
      .frame_done   (frame_done)
   );

   always #5 clock = ~clock;

   // Safety net so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Reference model: the frame is a flat run of H*V pixels; the source pixel
   // is found by dividing screen coordinates by the replication factor.
   task automatic modelStep(input int en, input int rs, input int sel);
      int p;
      if (rs != 0) begin
         mx = 0;
         my = 0;
         if (sel < NB) mbuf = sel;
         mdone = 0;
      end else if (en != 0) begin
         p = my * H + mx + 1;
         mdone = (p == H * V) ? 1 : 0;
         if (p == H * V) begin
            p = 0;
            if (sel < NB) mbuf = sel;
         end
         mx = p % H;
         my = p / H;
      end else begin
         mdone = 0;
      end
   endtask

   task automatic checkOutput(input string tag);
      int srcw;
      int exp_addr;
      srcw     = H / (1 << S);
      exp_addr = mbuf * srcw * (V / (1 << S)) + (my / (1 << S)) * srcw + mx / (1 << S);
      checkVal({tag, ".x"},          x_pos,        mx);
      checkVal({tag, ".y"},          y_pos,        my);
      checkVal({tag, ".addr"},       read_address, exp_addr);
      checkVal({tag, ".buf"},        active_buf,   mbuf);
      checkVal({tag, ".line_end"},   line_end,     (mx == H - 1) ? 1 : 0);
      checkVal({tag, ".frame_end"},  frame_end,    (mx == H - 1 && my == V - 1) ? 1 : 0);
      checkVal({tag, ".frame_done"}, frame_done,   mdone);
   endtask

   task automatic applyStimulus(input int en, input int rs, input int sel, input string tag);
      enable  = (en != 0);
      restart = (rs != 0);
      buf_sel = BW'(sel);
      @(posedge clock);
      modelStep(en, rs, sel);
      #1;
      checkOutput(tag);
   endtask

   initial begin
      int en;
      int rs;
      int sel;

      // Reset state
      reset = 1'b0;
      #12;
      checkOutput("reset");
      @(negedge clock);
      reset = 1'b1;

      // First frame up to the last pixel, then the wrap
      repeat (31) applyStimulus(1, 0, 0, "run");
      checkVal("last.x", x_pos, 7);
      checkVal("last.y", y_pos, 3);
      checkVal("last.addr", read_address, 7);
      checkVal("last.frame_end", frame_end, 1);
      applyStimulus(1, 0, 0, "wrap");
      checkVal("wrap.done", frame_done, 1);
      checkVal("wrap.addr", read_address, 0);
      applyStimulus(0, 0, 0, "done_clear");
      checkVal("done_clear.done", frame_done, 0);

      // Replicated lines
      repeat (11) applyStimulus(1, 0, 0, "to31");
      checkVal("p31.addr", read_address, 1);
      repeat (5) applyStimulus(1, 0, 0, "to02");
      checkVal("p02.addr", read_address, 4);

      // Buffer switch requested mid-frame takes effect at the wrap
      applyStimulus(1, 1, 0, "restart0");
      repeat (10) applyStimulus(1, 0, 0, "to21");
      repeat (21) applyStimulus(1, 0, 1, "sel_pending");
      checkVal("pending.buf", active_buf, 0);
      applyStimulus(1, 0, 1, "sel_wrap");
      checkVal("sel_wrap.buf", active_buf, 1);
      checkVal("sel_wrap.addr", read_address, 8);
      repeat (31) applyStimulus(1, 0, 1, "buf1_run");
      checkVal("buf1_last.addr", read_address, 15);

      // restart with enable at (5,2)
      applyStimulus(1, 0, 1, "buf1_wrap");
      repeat (21) applyStimulus(1, 0, 1, "to52");
      checkVal("p52.x", x_pos, 5);
      applyStimulus(1, 1, 1, "restart_en");
      checkVal("restart_en.addr", read_address, 8);
      checkVal("restart_en.done", frame_done, 0);

      // enable toggling 1,0,0,1
      applyStimulus(1, 0, 1, "tog1");
      applyStimulus(0, 0, 1, "tog0a");
      applyStimulus(0, 0, 1, "tog0b");
      applyStimulus(1, 0, 1, "tog1b");
      checkVal("toggle.x", x_pos, 2);

      // Asynchronous reset at (6,3) on buffer 1
      repeat (28) applyStimulus(1, 0, 1, "to63");
      checkVal("p63.buf", active_buf, 1);
      #2;
      reset = 1'b0;
      #1;
      mx = 0; my = 0; mbuf = 0; mdone = 0;
      checkOutput("async_reset");
      @(negedge clock);
      reset = 1'b1;

      // Out-of-range buffer select is ignored
      applyStimulus(0, 1, 1, "restart_sel1");
      applyStimulus(0, 1, 3, "restart_sel3");
      checkVal("sel3.buf", active_buf, 1);

      // Randomized traffic
      repeat (400) begin
         en  = ($urandom_range(0, 3) != 0) ? 1 : 0;
         rs  = ($urandom_range(0, 31) == 0) ? 1 : 0;
         sel = $urandom_range(0, 3);
         applyStimulus(en, rs, sel, "rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
